// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg: shared types and constants for the dmem_resp data-memory
// responder (state encoding, word/byte-enable types, bytes per word).
package dmem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  be_t;

  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/dmem_resp_if.sv
// dmem_resp_if: request/response bundle between a load/store requester and
// the dmem_resp responder.
//   request : req_valid, req_ready, req_we, req_addr, req_wdata, req_be
//   response: rsp_valid, rsp_ready, rsp_rdata, rsp_err
// modport master = requester side, modport slave = responder side.
interface dmem_resp_if;
  import dmem_resp_pkg::*;

  logic  req_valid;
  logic  req_ready;
  logic  req_we;
  word_t req_addr;
  word_t req_wdata;
  be_t   req_be;
  logic  rsp_valid;
  logic  rsp_ready;
  word_t rsp_rdata;
  logic  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_resp_array.sv
// dmem_resp_array: single-port synchronous RAM, DEPTH_WORDS x 32 bits, with
// per-byte write enables and a registered read.
//   clk   : rising-edge clock
//   en    : perform an access this edge
//   we    : 1 = write enabled byte lanes, 0 = read word into rdata
//   addr  : word index
//   be    : byte enables (bit i -> wdata[8i+7:8i])
//   wdata : write data
//   rdata : registered read data (holds its value on writes / idle cycles)
// Contents are not reset.
module dmem_resp_array
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  be_t           be,
  input  word_t         wdata,
  output word_t         rdata
);

  word_t mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: multi-cycle data-memory responder. Accepts one load/store at a
// time, waits LATENCY cycles, performs the access on the edge entering RESP
// and holds the response until the requester takes it.
//   clk   : rising-edge clock
//   reset : asynchronous reset, active low
//   bus   : dmem_resp_if.slave (req_* request handshake, rsp_* response)
// Parameters: DEPTH_WORDS (power of two, >= 2), LATENCY (0..15),
//   BASE_ADDR (byte address of word 0, aligned to DEPTH_WORDS*4).
// Optional macro DMEM_RESP_CHECK_EN: flags misaligned or out-of-range
//   requests with rsp_err=1 (no write, zero read data). Without it the
//   address low bits are ignored, the word index wraps and rsp_err is 0.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2,
  parameter word_t       BASE_ADDR   = 32'h0000_0000
) (
  input logic        clk,
  input logic        reset,
  dmem_resp_if.slave bus
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAST_WAIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       accept;
  logic       access;

  logic  we_q;
  word_t addr_q;
  word_t wdata_q;
  be_t   be_q;

  // With LATENCY=0 the access happens on the accepting edge, so the access
  // path reads the live request in IDLE and the latched copy otherwise.
  logic          acc_we;
  word_t         acc_addr;
  word_t         acc_wdata;
  be_t           acc_be;
  logic          acc_err;
  word_t         offset;
  logic [AW-1:0] acc_idx;
  word_t         arr_rdata;
  logic          rsp_err_int;

  assign accept = (state == IDLE) && bus.req_valid;

  always_comb begin
    if (state == IDLE) begin
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_be    = bus.req_be;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

  assign offset  = acc_addr - BASE_ADDR;
  assign acc_idx = offset[AW+1:2];

`ifdef DMEM_RESP_CHECK_EN
  logic err_q;

  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr < BASE_ADDR) ||
                   ({1'b0, offset} >= 33'(DEPTH_WORDS * BYTES_PER_WORD));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= acc_err;
    end
  end

  assign rsp_err_int = err_q;
`else
  logic unused_offset_bits;

  assign acc_err            = 1'b0;
  assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};
  assign rsp_err_int        = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    access    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          cnt_nxt = '0;
          if (LATENCY == 0) begin
            access    = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == LAST_WAIT) begin
          access    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      be_q    <= bus.req_be;
    end
  end

  // The RAM has no reset; gating with reset keeps an edge during reset
  // (LATENCY=0 with req_valid high) from touching memory.
  dmem_resp_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .en    (access && reset),
    .we    (acc_we && !acc_err),
    .addr  (acc_idx),
    .be    (acc_be),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  // The RAM read register only changes on a load access, so it is stable
  // for the whole of RESP; masking outside RESP gives the zero idle value.
  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_err   = (state == RESP) && rsp_err_int;
  assign bus.rsp_rdata = ((state == RESP) && !we_q && !rsp_err_int) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: self-checking bench for dmem_resp. Two instances (LATENCY=2
// and LATENCY=0) are checked every cycle against a transaction-level model;
// directed cases pin literal values. Honours DMEM_RESP_CHECK_EN.
module tb_dmem_resp;
  import dmem_resp_pkg::*;

  localparam int unsigned DEPTH = 64;
  localparam word_t       BASE  = 32'h0000_0000;
  localparam int unsigned LAT0  = 2;
  localparam int unsigned LAT1  = 0;
`ifdef DMEM_RESP_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_resp_if bus0 ();
  dmem_resp_if bus1 ();

  dmem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0), .BASE_ADDR(BASE)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  dmem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1), .BASE_ADDR(BASE)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic chk(input string nm, input word_t act, input word_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  word_t       mdl_mem [2][DEPTH];
  bit          m_busy [2];
  bit          m_vis  [2];
  bit          m_we   [2];
  bit          m_err  [2];
  int unsigned m_due  [2];
  word_t       m_addr [2];
  word_t       m_wdata[2];
  word_t       m_rdata[2];
  be_t         m_be   [2];
  int unsigned ecnt = 0;

  function automatic bit addr_is_err(input word_t a);
    return CHK_EN && ((a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + DEPTH * 4));
  endfunction

  function automatic int unsigned idx_of(input word_t a);
    return ((a - BASE) >> 2) % DEPTH;
  endfunction

  task automatic do_access(input int k);
    int unsigned i;
    i        = idx_of(m_addr[k]);
    m_err[k] = addr_is_err(m_addr[k]);
    if (m_we[k]) begin
      if (!m_err[k])
        for (int b = 0; b < 4; b++)
          if (m_be[k][b]) mdl_mem[k][i][8*b +: 8] = m_wdata[k][8*b +: 8];
      m_rdata[k] = '0;
    end else begin
      m_rdata[k] = m_err[k] ? '0 : mdl_mem[k][i];
    end
    m_vis[k] = 1'b1;
  endtask

  task automatic model_edge(input int k, input int unsigned lat, input logic v,
                            input logic we, input word_t a, input word_t wd,
                            input be_t be, input logic rr);
    if (m_busy[k] && m_vis[k]) begin
      if (rr) begin
        m_busy[k] = 1'b0;
        m_vis[k]  = 1'b0;
      end
    end else if (m_busy[k]) begin
      if (ecnt == m_due[k]) do_access(k);
    end else if (v) begin
      m_busy[k]  = 1'b1;
      m_vis[k]   = 1'b0;
      m_we[k]    = we;
      m_addr[k]  = a;
      m_wdata[k] = wd;
      m_be[k]    = be;
      m_due[k]   = ecnt + lat;
      if (lat == 0) do_access(k);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k] = 1'b0;
        m_vis[k]  = 1'b0;
      end
    end else begin
      ecnt++;
      model_edge(0, LAT0, bus0.req_valid, bus0.req_we, bus0.req_addr,
                 bus0.req_wdata, bus0.req_be, bus0.rsp_ready);
      model_edge(1, LAT1, bus1.req_valid, bus1.req_we, bus1.req_addr,
                 bus1.req_wdata, bus1.req_be, bus1.rsp_ready);
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("req_ready0", 32'(bus0.req_ready), 32'(!m_busy[0]));
    chk("rsp_valid0", 32'(bus0.rsp_valid), 32'(m_vis[0]));
    chk("rsp_rdata0", bus0.rsp_rdata, m_vis[0] ? m_rdata[0] : 32'h0);
    chk("rsp_err0",   32'(bus0.rsp_err), 32'(m_vis[0] && m_err[0]));
    chk("req_ready1", 32'(bus1.req_ready), 32'(!m_busy[1]));
    chk("rsp_valid1", 32'(bus1.rsp_valid), 32'(m_vis[1]));
    chk("rsp_rdata1", bus1.rsp_rdata, m_vis[1] ? m_rdata[1] : 32'h0);
    chk("rsp_err1",   32'(bus1.rsp_err), 32'(m_vis[1] && m_err[1]));
  end

  // ---------------- response-side ready driver ----------------
  int rr_mode [2] = '{1, 1};  // 0 random, 1 always high, 2 always low

  function automatic logic pick(input int mode);
    if (mode == 0) return 1'($urandom_range(0, 1));
    return (mode == 1);
  endfunction

  initial begin
    bus0.rsp_ready = 1'b0;
    bus1.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus0.rsp_ready = pick(rr_mode[0]);
      bus1.rsp_ready = pick(rr_mode[1]);
    end
  end

  // ---------------- request helpers ----------------
  task automatic drive(input int k, input logic v, input logic we, input word_t a,
                       input word_t wd, input be_t be);
    if (k == 0) begin
      bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = a;
      bus0.req_wdata = wd; bus0.req_be = be;
    end else begin
      bus1.req_valid = v; bus1.req_we = we; bus1.req_addr = a;
      bus1.req_wdata = wd; bus1.req_be = be;
    end
  endtask

  function automatic logic rdy(input int k);
    return (k == 0) ? bus0.req_ready : bus1.req_ready;
  endfunction
  function automatic logic vld(input int k);
    return (k == 0) ? bus0.rsp_valid : bus1.rsp_valid;
  endfunction
  function automatic word_t rdat(input int k);
    return (k == 0) ? bus0.rsp_rdata : bus1.rsp_rdata;
  endfunction
  function automatic logic rerr(input int k);
    return (k == 0) ? bus0.rsp_err : bus1.rsp_err;
  endfunction

  // Returns just after the accepting edge, with the inputs scrambled.
  task automatic send(input int k, input logic we, input word_t a, input word_t wd,
                      input be_t be);
    int unsigned n = 0;
    drive(k, 1'b1, we, a, wd, be);
    while (!rdy(k) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(k)) begin
      tests++;
      fails++;
      $display("FAIL send_timeout dut%0d: req_ready got %b, required 1", k, rdy(k));
    end
    @(posedge clk);
    #1;
    drive(k, 1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
  endtask

  task automatic wait_rsp(input int k, output int unsigned c, output word_t rd,
                          output logic er);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!vld(k) && c < 200);
    if (!vld(k)) begin
      tests++;
      fails++;
      $display("FAIL rsp_timeout dut%0d: rsp_valid got 0, required 1", k);
    end
    rd = rdat(k);
    er = rerr(k);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time got %0t, required finish earlier", $time);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int unsigned c;
    word_t       rd, w0, a;
    logic        er;
    logic [3:0]  pat;
    word_t       d0, d1;
    int unsigned r, lat;

    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(bus0.req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    chk("reset_rsp_rdata", bus0.rsp_rdata, 32'h0);
    chk("reset_rsp_err",   32'(bus0.rsp_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Preload every word so the model knows the full RAM image.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < int'(DEPTH); i++) begin
        send(k, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF);
        wait_rsp(k, c, rd, er);
      end

    // Store then load, latency 2.
    send(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    wait_rsp(0, c, rd, er);
    chk("store_latency", c, 32'd3);
    chk("store_err", 32'(er), 32'd0);
    send(0, 1'b0, 32'h10, $urandom, 4'($urandom));
    wait_rsp(0, c, rd, er);
    chk("load_latency", c, 32'd3);
    chk("load_after_store", rd, 32'hDEADBEEF);

    // Byte-lane merge.
    send(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
    wait_rsp(0, c, rd, er);
    send(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    wait_rsp(0, c, rd, er);
    send(0, 1'b0, 32'h20, '0, '0);
    wait_rsp(0, c, rd, er);
    chk("byte_merge", rd, 32'h11BB33DD);

    // Response backpressure.
    rr_mode[0] = 2;
    send(0, 1'b0, 32'h20, '0, '0);
    wait_rsp(0, c, rd, er);
    chk("bp_first", rd, 32'h11BB33DD);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus0.rsp_valid), 32'd1);
      chk("bp_rdata", bus0.rsp_rdata, 32'h11BB33DD);
      chk("bp_req_ready", 32'(bus0.req_ready), 32'd0);
    end
    rr_mode[0] = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_ready", 32'(bus0.req_ready), 32'd1);
    chk("bp_release_valid", 32'(bus0.rsp_valid), 32'd0);

    // LATENCY=0 back-to-back loads.
    send(1, 1'b1, 32'h10, 32'h0BADF00D, 4'hF);
    wait_rsp(1, c, rd, er);
    chk("lat0_latency", c, 32'd1);
    send(1, 1'b1, 32'h20, 32'h12345678, 4'hF);
    wait_rsp(1, c, rd, er);
    @(negedge clk);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h10, '0, '0);
    pat[3] = bus1.req_ready;
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 32'h20, '0, '0);
    @(negedge clk);
    pat[2] = bus1.req_ready;
    d0 = bus1.rsp_rdata;
    @(negedge clk);
    pat[1] = bus1.req_ready;
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    pat[0] = bus1.req_ready;
    d1 = bus1.rsp_rdata;
    @(negedge clk);
    chk("lat0_ready_pattern", 32'(pat), 32'hA);
    chk("lat0_load_a", d0, 32'h0BADF00D);
    chk("lat0_load_b", d1, 32'h12345678);
    chk("lat0_done_ready", 32'(bus1.req_ready), 32'd1);

    // Misaligned load and out-of-range store.
    send(0, 1'b0, 32'h13, '0, '0);
    wait_rsp(0, c, rd, er);
    chk("misalign_err", 32'(er), 32'(CHK_EN));
    chk("misalign_rdata", rd, CHK_EN ? 32'h0 : 32'hDEADBEEF);
    w0 = mdl_mem[0][0];
    send(0, 1'b1, BASE + DEPTH * 4, 32'hCAFEF00D, 4'hF);
    wait_rsp(0, c, rd, er);
    chk("oor_err", 32'(er), 32'(CHK_EN));
    send(0, 1'b0, BASE, '0, '0);
    wait_rsp(0, c, rd, er);
    chk("oor_word0", rd, CHK_EN ? w0 : 32'hCAFEF00D);

    // Reset while a store waits.
    send(0, 1'b1, 32'h08, 32'h0, 4'hF);
    wait_rsp(0, c, rd, er);
    send(0, 1'b1, 32'h08, 32'hFFFFFFFF, 4'hF);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_wait_req_ready", 32'(bus0.req_ready), 32'd1);
    chk("rst_wait_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    chk("rst_wait_rsp_rdata", bus0.rsp_rdata, 32'h0);
    chk("rst_wait_rsp_err",   32'(bus0.rsp_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    send(0, 1'b0, 32'h08, '0, '0);
    wait_rsp(0, c, rd, er);
    chk("rst_store_dropped", rd, 32'h0);

    // Randomized traffic with random response backpressure.
    for (int k = 0; k < 2; k++) begin
      rr_mode[k] = 0;
      lat = (k == 0) ? LAT0 : LAT1;
      for (int n = 0; n < 150; n++) begin
        r = $urandom_range(0, 9);
        if (r < 7)       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        else if (r == 7) a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
        else             a = BASE + DEPTH * 4 + 32'(4 * $urandom_range(0, DEPTH - 1));
        send(k, 1'($urandom), a, $urandom, 4'($urandom));
        wait_rsp(k, c, rd, er);
        chk("rnd_latency", c, lat + 1);
      end
      rr_mode[k] = 1;
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
